// File: rtl/sha3_block_sequencer.sv
// sha3_block_sequencer: SHA3-256 front end that packs a 64-bit byte stream into 136-byte rate blocks, pads, and sequences the core.
// Optional SHA3_TIMEOUT_EN adds a bounded wait for the digest with a sticky err flag.
module sha3_block_sequencer #(
  parameter int CORE_CYCLES = 46,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [63:0]   s_data,
  input  logic          s_last,
  input  logic [3:0]    s_bytes,
  output logic [1087:0] core_in,
  output logic          core_in_valid,
  output logic          core_more,
  input  logic [255:0]  core_out,
  input  logic          core_out_valid,
  output logic [255:0]  dig,
  output logic          dig_valid,
  input  logic          dig_ready,
  output logic          err
);
  typedef enum logic [2:0] {IDLE, FILL, PAD, ISSUE, ABSORB, WAIT_DIG, OUT} state_t;
  localparam int AW = $clog2(CORE_CYCLES);
  localparam logic [1087:0] PAD_BLK = {8'h06, 1072'b0, 8'h80};
  state_t state_q, state_d;
  logic [1087:0] buf_q, buf_d;
  logic [7:0] cnt_q, cnt_d, sum;
  logic [AW-1:0] acnt_q, acnt_d;
  logic more_q, more_d, pend_q, pend_d, dv_q, dv_d;
  logic [255:0] dig_q, dig_d;
  logic [3:0] nb;
  logic [63:0] word;
`ifdef SHA3_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic err_q, err_d;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
  if (CORE_CYCLES < 2 || TIMEOUT < 1) begin : g_bad_params
    $error("CORE_CYCLES must be >= 2 and TIMEOUT >= 1");
  end
  assign s_ready       = state_q == FILL;
  assign core_in_valid = state_q == ISSUE;
  assign core_in       = buf_q;
  assign core_more     = more_q;
  assign dig           = dig_q;
  assign dig_valid     = dv_q;
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    acnt_d  = acnt_q;
    more_d  = more_q;
    pend_d  = pend_q;
    dig_d   = dig_q;
    dv_d    = dv_q;
`ifdef SHA3_TIMEOUT_EN
    tcnt_d  = tcnt_q;
    err_d   = err_q;
`endif
    nb   = (s_bytes > 4'd8) ? 4'd8 : s_bytes;
    // keep only the top nb bytes of the word; the rest must never reach the block
    word = s_data & ~(64'hFFFF_FFFF_FFFF_FFFF >> {nb, 3'b000});
    sum  = cnt_q + {4'b0, nb};
    case (state_q)
      IDLE: begin
        buf_d   = '0;
        cnt_d   = '0;
        more_d  = 1'b0;
        pend_d  = 1'b0;
        state_d = FILL;
      end
      FILL: if (s_valid) begin
        buf_d   = buf_q | ({word, 1024'b0} >> {cnt_q, 3'b000});
        cnt_d   = (sum > 8'd136) ? 8'd136 : sum;
        more_d  = !s_last;
        state_d = s_last ? PAD : (cnt_d == 8'd136) ? ISSUE : FILL;
`ifdef SHA3_TIMEOUT_EN
        err_d   = 1'b0;
`endif
      end
      PAD: begin
        // a message ending exactly on a block boundary needs a separate all-padding block
        more_d  = cnt_q == 8'd136;
        pend_d  = cnt_q == 8'd136;
        buf_d   = (cnt_q == 8'd136) ? buf_q
                : buf_q | ({8'h06, 1080'b0} >> {cnt_q, 3'b000}) | 1088'h80;
        state_d = ISSUE;
      end
      ISSUE: begin
        acnt_d  = '0;
        state_d = ABSORB;
`ifdef SHA3_TIMEOUT_EN
        tcnt_d  = '0;
`endif
      end
      ABSORB: begin
        acnt_d = acnt_q + 1'b1;
        if (acnt_q == AW'(CORE_CYCLES - 1)) begin
          buf_d   = !more_q ? buf_q : pend_q ? PAD_BLK : '0;
          cnt_d   = more_q ? 8'd0 : cnt_q;
          more_d  = more_q && !pend_q;
          pend_d  = 1'b0;
          state_d = !more_q ? WAIT_DIG : pend_q ? ISSUE : FILL;
        end
      end
      WAIT_DIG: begin
        if (core_out_valid) begin
          dig_d   = core_out;
          dv_d    = 1'b1;
          state_d = OUT;
        end
`ifdef SHA3_TIMEOUT_EN
        else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else tcnt_d = tcnt_q + 1'b1;
`endif
      end
      OUT: if (dig_ready) begin
        dv_d    = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      acnt_q  <= '0;
      more_q  <= 1'b0;
      pend_q  <= 1'b0;
      dig_q   <= '0;
      dv_q    <= 1'b0;
`ifdef SHA3_TIMEOUT_EN
      tcnt_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      acnt_q  <= acnt_d;
      more_q  <= more_d;
      pend_q  <= pend_d;
      dig_q   <= dig_d;
      dv_q    <= dv_d;
`ifdef SHA3_TIMEOUT_EN
      tcnt_q  <= tcnt_d;
      err_q   <= err_d;
`endif
    end
  end
endmodule

// File: tb/tb_sha3_block_sequencer.sv
// tb_sha3_block_sequencer: directed messages against a padding/sequence model plus a stub core returning fixed digests.
module tb_sha3_block_sequencer;
  localparam logic [1087:0] LIT_EMPTY = {8'h06, 1072'b0, 8'h80};
  localparam logic [1087:0] LIT_ABC   = {24'h616263, 8'h06, 1048'b0, 8'h80};
  localparam logic [255:0] DIG_EMPTY = 256'ha7ffc6f8bf1ed76651c14756a061d662f580ff4de43b49fa82d80a4b80f8434a;
  localparam logic [255:0] DIG_ABC   = 256'h3a985da74fe225b2045c172d6bd390bd855f086e3e9d525b46bfe24511431532;
  logic clk = 0, rst = 1, s_valid = 0, s_last = 0, dig_ready = 0, core_out_valid = 0;
  logic s_ready, core_in_valid, core_more, dig_valid, err;
  logic [63:0] s_data = '0;
  logic [3:0] s_bytes = '0;
  logic [1087:0] core_in;
  logic [255:0] core_out = '0, dig;
  int checks = 0, passes = 0, cyc = 0, issues = 0, last_issue = 0, since = 1000;
  logic [7:0] msg [0:299];
  logic [1087:0] exp_blk[$];
  bit exp_more[$];
  logic [1087:0] last_blk = '0, eb;
  bit em, last_more = 0, waiting = 0, exp_dv = 0, stub_en = 1, to_phase = 0;
  logic [255:0] exp_dig = '0, core_dig = '0;

  sha3_block_sequencer dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .s_bytes(s_bytes), .core_in(core_in), .core_in_valid(core_in_valid),
    .core_more(core_more), .core_out(core_out), .core_out_valid(core_out_valid),
    .dig(dig), .dig_valid(dig_valid), .dig_ready(dig_ready), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string nm, input logic [255:0] act, input logic [255:0] want);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, want);
  endtask

  task automatic blk_chk(input logic [1087:0] a, input logic [1087:0] e, input string nm);
    int k = 0;
    for (int i = 0; i < 136; i++)
      if (a[1087-8*i -: 8] != e[1087-8*i -: 8]) begin k = i; break; end
    chk(a == e, $sformatf("%s_byte%0d", nm, k), 256'(a[1087-8*k -: 8]), 256'(e[1087-8*k -: 8]));
  endtask

  // SHA3 padding: msg || 06 || 0.. || 80 up to a multiple of 136 bytes (06^80 = 86 when they coincide)
  task automatic push_model(input int n);
    int nblk = n / 136 + 1;
    logic [1087:0] blk;
    logic [7:0] v;
    for (int b = 0; b < nblk; b++) begin
      for (int i = 0; i < 136; i++) begin
        v = (b * 136 + i < n) ? msg[b*136+i] : 8'h00;
        if (b * 136 + i == n) v = v ^ 8'h06;
        if (b * 136 + i == nblk * 136 - 1) v = v ^ 8'h80;
        blk[1087-8*i -: 8] = v;
      end
      exp_blk.push_back(blk);
      exp_more.push_back(b < nblk - 1);
    end
  endtask

  task automatic send(input int n, input int maxw);
    int i = 0, w = 0, b, bound;
    bit last;
    logic [63:0] d;
    do begin
      b = (n - i > 8) ? 8 : n - i;
      last = (n - i <= 8);
      d = 64'hA5A5_A5A5_A5A5_A5A5;
      for (int k = 0; k < b; k++) d[63-8*k -: 8] = msg[i+k];
      s_data = d; s_bytes = 4'(b); s_last = last; s_valid = 1'b1;
      bound = 0;
      while (!s_ready && bound < 500) begin @(negedge clk); bound++; end
      chk(s_ready, "s_ready_wait", 256'(s_ready), 256'(1));
      if (!s_ready) break;
      @(negedge clk);
      i += b; w++;
    end while (!last && w != maxw);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic finish(input int hold);
    int bound = 0;
    while (!dig_valid && bound < 400) begin @(negedge clk); bound++; end
    chk(dig_valid, "dig_valid_wait", 256'(dig_valid), 256'(1));
    repeat (hold) @(negedge clk);
    dig_ready = 1'b1; @(negedge clk); dig_ready = 1'b0;
    chk(!dig_valid && !s_ready, "post_handshake", 256'({dig_valid, s_ready}), 256'(0));
    @(negedge clk);
    chk(s_ready, "s_ready_2cyc", 256'(s_ready), 256'(1));
  endtask

  task automatic run(input int n, input int hold);
    push_model(n);
    send(n, -1);
    finish(hold);
  endtask

  // single compare process: every cycle, #1 after the edge
  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst) begin
      exp_blk.delete(); exp_more.delete();
      waiting = 0; exp_dv = 0; since = 1000; last_more = 0;
      chk(!(s_ready | core_in_valid | core_more | dig_valid | err | (|core_in) | (|dig)), "reset_state",
          256'({s_ready, core_in_valid, core_more, dig_valid, err, |core_in, |dig}), 256'(0));
    end else begin
      if (exp_dv && dig_ready) exp_dv = 0;
      else if (waiting && core_out_valid) begin exp_dv = 1; exp_dig = core_out; waiting = 0; end
      chk(dig_valid == exp_dv, "dig_valid", 256'(dig_valid), 256'(exp_dv));
      if (exp_dv) chk(dig == exp_dig, "dig", dig, exp_dig);
      if ((waiting || exp_dv) && !to_phase) chk(!s_ready, "s_ready_busy", 256'(s_ready), 256'(0));
      if (!to_phase) chk(!err, "err_low", 256'(err), 256'(0));
      if (core_in_valid) begin
        chk(exp_blk.size() > 0, "issue_expected", 256'(exp_blk.size()), 256'(1));
        if (exp_blk.size() > 0) begin
          eb = exp_blk.pop_front(); em = exp_more.pop_front();
          blk_chk(core_in, eb, "core_in");
          chk(core_more == em, "core_more", 256'(core_more), 256'(em));
          if (last_more) chk(cyc - last_issue >= 46, "issue_gap", 256'(cyc - last_issue), 256'(46));
          if (!core_more) waiting = 1;
        end
        last_more = core_more; last_issue = cyc; last_blk = core_in; since = 0; issues++;
      end else begin
        since++;
        if (since < 46) chk(core_in == last_blk && core_more == last_more, "core_in_stable",
                            256'(core_in[1087:1080]), 256'(last_blk[1087:1080]));
      end
    end
  end

  // stub core: returns core_dig 60 cycles after the final block is issued
  initial forever begin
    @(negedge clk);
    if (core_in_valid && !core_more && !rst && stub_en) begin
      repeat (60) @(negedge clk);
      core_out = core_dig; core_out_valid = 1'b1;
      @(negedge clk);
      core_out_valid = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bound;
    repeat (3) @(negedge clk);
    rst = 0;
    core_dig = DIG_EMPTY; issues = 0;
    run(0, 3);
    blk_chk(last_blk, LIT_EMPTY, "empty_blk");
    chk(issues == 1, "empty_issues", 256'(issues), 256'(1));
    chk(dig == DIG_EMPTY, "empty_dig", dig, DIG_EMPTY);
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    core_dig = DIG_ABC; issues = 0;
    run(3, 2);
    blk_chk(last_blk, LIT_ABC, "abc_blk");
    chk(issues == 1, "abc_issues", 256'(issues), 256'(1));
    chk(dig == DIG_ABC, "abc_dig", dig, DIG_ABC);
    for (int i = 0; i < 300; i++) msg[i] = 8'(i * 7 + 1);
    core_dig = {8{32'hC0DE_0135}}; issues = 0;
    run(135, 1);
    chk(issues == 1, "m135_issues", 256'(issues), 256'(1));
    chk(last_blk[7:0] == 8'h86, "m135_last_byte", 256'(last_blk[7:0]), 256'(8'h86));
    core_dig = {8{32'hC0DE_0136}}; issues = 0;
    run(136, 1);
    chk(issues == 2, "m136_issues", 256'(issues), 256'(2));
    blk_chk(last_blk, LIT_EMPTY, "m136_pad_blk");
    core_dig = {8{32'hBEEF_0020}};
    run(20, 20);
    chk(dig == {8{32'hBEEF_0020}}, "hold_dig", dig, {8{32'hBEEF_0020}});
    send(64, 3);
    rst = 1; @(negedge clk); rst = 0;
    core_dig = {8{32'h0000_0A0A}}; issues = 0;
    run(10, 2);
    chk(issues == 1, "after_fill_rst_issues", 256'(issues), 256'(1));
    push_model(16); issues = 0;
    send(16, -1);
    bound = 0;
    while (issues == 0 && bound < 200) begin @(negedge clk); bound++; end
    chk(issues == 1, "absorb_issue_seen", 256'(issues), 256'(1));
    repeat (10) @(negedge clk);
    rst = 1; @(negedge clk); rst = 0;
    repeat (80) @(negedge clk);
    chk(!dig_valid && issues == 1, "after_absorb_rst", 256'({dig_valid, 8'(issues)}), 256'(1));
    core_dig = {8{32'h5555_0005}};
    run(5, 1);
    chk(dig == {8{32'h5555_0005}}, "after_rst_dig", dig, {8{32'h5555_0005}});
`ifdef SHA3_TIMEOUT_EN
    stub_en = 0; to_phase = 1;
    push_model(4);
    send(4, -1);
    repeat (46 + 255 + 30) @(negedge clk);
    chk(err, "timeout_err", 256'(err), 256'(1));
    chk(!dig_valid, "timeout_no_dig", 256'(dig_valid), 256'(0));
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
